// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA constants and helpers for the MineSweeper video path.
//   - default 640x480 timing constants (back porches, line/frame totals)
//   - rgb332_t and a field-split helper for 8-bit 3/3/2 colour
//   - cursor highlight mode encodings
package vga_pkg;

  localparam int unsigned VGA_HBP  = 144;
  localparam int unsigned VGA_VBP  = 31;
  localparam int unsigned VGA_HMAX = 800;
  localparam int unsigned VGA_VMAX = 521;

  typedef enum logic {
    HL_RED_SAT = 1'b0,  // red channel +1, saturating at 7
    HL_INVERT  = 1'b1   // bitwise invert of the whole pixel
  } hl_mode_e;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  function automatic rgb332_t rgb332_split(input logic [7:0] pix);
    return rgb332_t'(pix);
  endfunction

endpackage

// File: rtl/vga_blink_ctr.sv
// vga_blink_ctr: cursor blink phase generator.
//   clk, clr_n : pixel clock, asynchronous active-low reset
//   hc_i, vc_i : raster counters; hc == 0 && vc == 0 marks a new frame
//   phase_o    : toggles every BLINK_FR frames, 0 out of reset
module vga_blink_ctr #(
  parameter int unsigned BLINK_FR = 30
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [9:0] hc_i,
  input  logic [9:0] vc_i,
  output logic       phase_o
);

  localparam int unsigned CW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
  localparam logic [CW-1:0] LAST = CW'(BLINK_FR - 1);

  logic [CW-1:0] cnt_q;
  logic          phase_q;
  logic          tick;

  assign tick = (hc_i == '0) && (vc_i == '0);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else if (tick) begin
      if (cnt_q == LAST) begin
        cnt_q   <= '0;
        phase_q <= ~phase_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign phase_o = phase_q;

endmodule

// File: rtl/vga_grid_sprite.sv
// vga_grid_sprite: pipelined board/face sprite renderer with cursor highlight.
//   clk, clr_n           : pixel clock, asynchronous active-low reset
//   vidon, hs_in, vs_in  : video-enable and syncs aligned with hc/vc
//   hc, vc               : raster counters
//   posx, posy, blink_en : cursor tile and blink enable
//   tile_col, tile_row   : board cell of the current pixel (stage 1)
//   rom_addr_tile/_face  : registered ROM addresses (stage 1)
//   tile_pix, face_pix   : ROM data, one clock after the addresses
//   red, green, blue     : 3/3/2 colour, 3 clocks after hc/vc
//   hs_out, vs_out       : syncs delayed by 3 clocks to match the colour
module vga_grid_sprite
  import vga_pkg::*;
#(
  parameter int unsigned HBP      = VGA_HBP,
  parameter int unsigned VBP      = VGA_VBP,
  parameter int unsigned GX0      = 240,
  parameter int unsigned GY0      = 200,
  parameter int unsigned COLS     = 10,
  parameter int unsigned ROWS     = 10,
  parameter int unsigned TL2      = 4,
  parameter int unsigned FX0      = 307,
  parameter int unsigned FY0      = 174,
  parameter int unsigned FACE_W   = 26,
  parameter int unsigned FACE_H   = 26,
  parameter int unsigned FAW      = 10,
  parameter int unsigned BLINK_FR = 30,
  parameter int unsigned HL_MODE  = 0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             vidon,
  input  logic             hs_in,
  input  logic             vs_in,
  input  logic [9:0]       hc,
  input  logic [9:0]       vc,
  input  logic [3:0]       posx,
  input  logic [3:0]       posy,
  input  logic             blink_en,
  output logic [3:0]       tile_col,
  output logic [3:0]       tile_row,
  output logic [2*TL2-1:0] rom_addr_tile,
  output logic [FAW-1:0]   rom_addr_face,
  input  logic [7:0]       tile_pix,
  input  logic [7:0]       face_pix,
  output logic [2:0]       red,
  output logic [2:0]       green,
  output logic [1:0]       blue,
  output logic             hs_out,
  output logic             vs_out
);

  localparam int unsigned BW = COLS << TL2;
  localparam int unsigned BH = ROWS << TL2;
  localparam hl_mode_e    HL = hl_mode_e'(HL_MODE[0]);

  // ---------------- stage 1: region decode and address generation
  logic [9:0]       x, y, xo, yo;
  logic             board_on, face_on, face_sol;
  logic [3:0]       tile_col_q, tile_col_d, tile_row_q, tile_row_d;
  logic [2*TL2-1:0] addr_t_q, addr_t_d;
  logic [FAW-1:0]   addr_f_q, addr_f_d, base_q, base_d, col_q, col_d, col_eff;
  logic             board1_q, face1_q, vid1_q;

  always_comb begin
    x  = hc - 10'(HBP);
    y  = vc - 10'(VBP);
    xo = x - 10'(GX0);
    yo = y - 10'(GY0);
    board_on = (x >= 10'(GX0)) && ({1'b0, x} < 11'(GX0 + BW)) &&
               (y >= 10'(GY0)) && ({1'b0, y} < 11'(GY0 + BH));
    face_on  = (x >= 10'(FX0)) && ({1'b0, x} < 11'(FX0 + FACE_W)) &&
               (y >= 10'(FY0)) && ({1'b0, y} < 11'(FY0 + FACE_H));
    // start of a face line: reload the line base, restart the column
    face_sol = face_on && (x == 10'(FX0));

    tile_col_d = board_on ? 4'(xo >> TL2) : tile_col_q;
    tile_row_d = board_on ? 4'(yo >> TL2) : tile_row_q;
    addr_t_d   = board_on ? {yo[TL2-1:0], xo[TL2-1:0]} : addr_t_q;

    // face address = line base + column, built without a multiplier
    base_d  = base_q;
    if (face_sol) base_d = (y == 10'(FY0)) ? '0 : base_q + FAW'(FACE_W);
    col_eff  = face_sol ? '0 : col_q;
    col_d    = face_on ? col_eff + 1'b1 : col_q;
    addr_f_d = face_on ? base_d + col_eff : addr_f_q;
  end

  // ---------------- stage 2 registers
  logic board2_q, face2_q, vid2_q, hit2_q;

  // ---------------- stage 3: colour select
  logic       phase, show_hl;
  logic [7:0] rgb_q, rgb_d;
  rgb332_t    px;
  logic [2:0] hs_sr_q, vs_sr_q;

  assign show_hl = ~blink_en | phase;

  always_comb begin
    px    = rgb332_split(tile_pix);
    rgb_d = '0;
    if (vid2_q && board2_q) begin
      rgb_d = tile_pix;
      if (hit2_q && show_hl) begin
        if (HL == HL_INVERT) rgb_d = ~tile_pix;
        else rgb_d = {(px.r == 3'd7) ? 3'd7 : px.r + 3'd1, px.g, px.b};
      end
    end else if (vid2_q && face2_q) begin
      rgb_d = face_pix;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tile_col_q <= '0;
      tile_row_q <= '0;
      addr_t_q   <= '0;
      addr_f_q   <= '0;
      base_q     <= '0;
      col_q      <= '0;
      board1_q   <= 1'b0;
      face1_q    <= 1'b0;
      vid1_q     <= 1'b0;
      board2_q   <= 1'b0;
      face2_q    <= 1'b0;
      vid2_q     <= 1'b0;
      hit2_q     <= 1'b0;
      rgb_q      <= '0;
      hs_sr_q    <= '1;
      vs_sr_q    <= '1;
    end else begin
      tile_col_q <= tile_col_d;
      tile_row_q <= tile_row_d;
      addr_t_q   <= addr_t_d;
      addr_f_q   <= addr_f_d;
      base_q     <= base_d;
      col_q      <= col_d;
      board1_q   <= board_on;
      face1_q    <= face_on && !board_on;
      vid1_q     <= vidon;
      board2_q   <= board1_q;
      face2_q    <= face1_q;
      vid2_q     <= vid1_q;
      hit2_q     <= (tile_col_q == posx) && (tile_row_q == posy);
      rgb_q      <= rgb_d;
      hs_sr_q    <= {hs_sr_q[1:0], hs_in};
      vs_sr_q    <= {vs_sr_q[1:0], vs_in};
    end
  end

  vga_blink_ctr #(.BLINK_FR(BLINK_FR)) u_blink (
    .clk     (clk),
    .clr_n   (clr_n),
    .hc_i    (hc),
    .vc_i    (vc),
    .phase_o (phase)
  );

  assign tile_col      = tile_col_q;
  assign tile_row      = tile_row_q;
  assign rom_addr_tile = addr_t_q;
  assign rom_addr_face = addr_f_q;
  assign red           = rgb_q[7:5];
  assign green         = rgb_q[4:2];
  assign blue          = rgb_q[1:0];
  assign hs_out        = hs_sr_q[2];
  assign vs_out        = vs_sr_q[2];

endmodule

// File: tb/tb_vga_grid_sprite.sv
// tb_vga_grid_sprite: randomized + directed bench for vga_grid_sprite.
// Two instances (highlight modes 0 and 1) share the raster stimulus; each
// has its own ROM model fed from its own addresses.
module tb_vga_grid_sprite;

  localparam int HBP = 144, VBP = 31, GX0 = 240, GY0 = 200;
  localparam int COLS = 10, ROWS = 10, TILE = 16;
  localparam int FX0 = 307, FY0 = 174, FW = 26, FH = 26, BFR = 2;
  localparam logic [9:0] RST = 10'h003;   // black, hs/vs inactive

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       vidon = 1'b0, hs_in = 1'b1, vs_in = 1'b1, blink_en = 1'b0;
  logic [9:0] hc = '0, vc = '0;
  logic [3:0] posx = '0, posy = '0;

  logic [3:0] tc0, tr0, tc1, tr1;
  logic [7:0] at0, at1, tp0, tp1, fp0, fp1;
  logic [9:0] af0, af1;
  logic [2:0] r0, g0, r1, g1;
  logic [1:0] b0, b1;
  logic       hso0, vso0, hso1, vso1;

  always #5 clk = ~clk;

  vga_grid_sprite #(.BLINK_FR(BFR), .HL_MODE(0)) dut0 (
    .clk(clk), .clr_n(clr_n), .vidon(vidon), .hs_in(hs_in), .vs_in(vs_in),
    .hc(hc), .vc(vc), .posx(posx), .posy(posy), .blink_en(blink_en),
    .tile_col(tc0), .tile_row(tr0), .rom_addr_tile(at0), .rom_addr_face(af0),
    .tile_pix(tp0), .face_pix(fp0), .red(r0), .green(g0), .blue(b0),
    .hs_out(hso0), .vs_out(vso0));

  vga_grid_sprite #(.BLINK_FR(BFR), .HL_MODE(1)) dut1 (
    .clk(clk), .clr_n(clr_n), .vidon(vidon), .hs_in(hs_in), .vs_in(vs_in),
    .hc(hc), .vc(vc), .posx(posx), .posy(posy), .blink_en(blink_en),
    .tile_col(tc1), .tile_row(tr1), .rom_addr_tile(at1), .rom_addr_face(af1),
    .tile_pix(tp1), .face_pix(fp1), .red(r1), .green(g1), .blue(b1),
    .hs_out(hso1), .vs_out(vso1));

  // ROM contents: fixed hash of the address, or a forced constant
  bit         ovr_en = 1'b0;
  logic [7:0] ovr_val = '0;

  function automatic logic [7:0] rom_t(input logic [3:0] c, input logic [3:0] r,
                                       input logic [7:0] a);
    if (ovr_en) return ovr_val;
    return 8'(int'(a) * 37 + int'(c) * 11 + int'(r) * 101 + 5);
  endfunction

  function automatic logic [7:0] rom_f(input logic [9:0] a);
    return 8'(int'(a) * 13 + (int'(a) >> 3) + 7);
  endfunction

  always @(posedge clk) begin
    tp0 <= rom_t(tc0, tr0, at0);
    tp1 <= rom_t(tc1, tr1, at1);
    fp0 <= rom_f(af0);
    fp1 <= rom_f(af1);
  end

  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [9:0] qa[$], qb[$];          // expected {rgb,hs,vs}, 3 pixels deep
  logic [3:0] m_tc = '0, m_tr = '0;
  logic [7:0] m_at = '0;
  logic [9:0] m_af = '0;
  int         ticks = 0;

  function automatic logic [7:0] hl0(input logic [7:0] p);
    if (p[7:5] == 3'd7) return p;
    return {p[7:5] + 3'd1, p[4:0]};
  endfunction

  function automatic bit in_face(input int h, input int v);
    int xi, yi;
    xi = int'(10'(h - HBP));
    yi = int'(10'(v - VBP));
    return xi >= FX0 && xi < FX0 + FW && yi >= FY0 && yi < FY0 + FH;
  endfunction

  // One pixel clock: check what is due now, then drive the next pixel.
  task automatic step(input int h, input int v, input bit vid, input bit hs,
                      input bit vs, input bit rstn);
    int xi, yi, c, r;
    bit brd, fcr, hit, show;
    logic [7:0] t, p0, p1;
    @(negedge clk);
    chk("out_m0", {r0, g0, b0, hso0, vso0}, qa.pop_front());
    chk("out_m1", {r1, g1, b1, hso1, vso1}, qb.pop_front());
    chk("tile_addr", {tc0, tr0, at0}, {m_tc, m_tr, m_at});
    chk("face_addr", af0, m_af);
    hc = 10'(h); vc = 10'(v); vidon = vid; hs_in = hs; vs_in = vs;
    if (!rstn) begin
      if (clr_n) begin
        clr_n = 1'b0;
        #1;
        chk("rst_blank", {r0, g0, b0, hso0, vso0, r1, g1, b1, hso1, vso1},
            {RST, RST});
        chk("rst_addr", {tc0, tr0, at0, af0}, 32'h0);
        qa.delete(); qb.delete();
        repeat (2) begin qa.push_back(RST); qb.push_back(RST); end
        m_tc = '0; m_tr = '0; m_at = '0; m_af = '0; ticks = 0;
      end
      qa.push_back(RST); qb.push_back(RST);
      return;
    end
    clr_n = 1'b1;
    if (h == 0 && v == 0) ticks++;
    xi = int'(10'(h - HBP));
    yi = int'(10'(v - VBP));
    brd = xi >= GX0 && xi < GX0 + COLS * TILE && yi >= GY0 && yi < GY0 + ROWS * TILE;
    fcr = in_face(h, v) && !brd;
    c = (xi - GX0) / TILE;
    r = (yi - GY0) / TILE;
    if (brd) begin
      m_tc = 4'(c); m_tr = 4'(r);
      m_at = {4'((yi - GY0) % TILE), 4'((xi - GX0) % TILE)};
    end
    if (in_face(h, v)) m_af = 10'((yi - FY0) * FW + (xi - FX0));
    hit  = brd && c == int'(posx) && r == int'(posy);
    show = !blink_en || ((ticks / BFR) % 2 == 1);
    t = rom_t(m_tc, m_tr, m_at);
    if (vid && brd) begin
      p0 = (hit && show) ? hl0(t) : t;
      p1 = (hit && show) ? ~t : t;
    end else if (vid && fcr) begin
      p0 = rom_f(m_af); p1 = p0;
    end else begin
      p0 = '0; p1 = '0;
    end
    qa.push_back({p0, hs, vs});
    qb.push_back({p1, hs, vs});
  endtask

  task automatic pad(input int n);
    repeat (n) step(1, 0, 0, 1, 1, 1);
  endtask

  // Drive one pixel and read its colour back once it has crossed the pipe.
  task automatic probe(input string tag, input int h, input int v,
                       input logic [7:0] e0, input logic [7:0] e1);
    step(h, v, 1, 1, 1, 1);
    pad(2);
    @(posedge clk); #1;
    chk({tag, "_m0"}, {r0, g0, b0}, e0);
    chk({tag, "_m1"}, {r1, g1, b1}, e1);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, v, tk;
    repeat (3) begin qa.push_back(RST); qb.push_back(RST); end
    #1 clr_n = 1'b0;

    // reset held while pixels sweep across the board
    repeat (6) step(HBP + GX0 + $urandom_range(0, 159), VBP + GY0 + $urandom_range(0, 159),
                    1, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    pad(4);

    // board mapping and forced tile data
    posx = 4'd9; posy = 4'd9; ovr_en = 1; ovr_val = 8'hA5;
    pad(3);
    step(419, 249, 1, 1, 1, 1);
    @(posedge clk); #1;
    chk("map_tile", {tc0, tr0, at0}, {4'd2, 4'd1, 8'h23});
    pad(2);
    @(posedge clk); #1;
    chk("map_rgb", {r0, g0, b0}, 8'hA5);
    pad(2);

    // cursor highlight, always shown
    posx = 4'd2; posy = 4'd1; blink_en = 0; ovr_val = 8'hE4;
    pad(3);
    probe("hl_e4", 419, 249, 8'hE4, 8'h1B);
    ovr_val = 8'hA5;
    pad(3);
    probe("hl_a5", 419, 249, 8'hC5, 8'h5A);
    probe("hl_vidoff_ref", 420, 249, 8'hC5, 8'h5A);
    step(420, 249, 0, 1, 1, 1);
    pad(2);
    @(posedge clk); #1;
    chk("vidon_off", {r0, g0, b0}, 8'h00);
    pad(2);
    ovr_en = 0;
    pad(3);

    // right / bottom board edges, sync edges
    for (int k = 0; k < 4; k++) begin
      step(HBP + GX0 + 158 + k, VBP + GY0 + 40, 1, k[0], k[1], 1);
      step(HBP + GX0 + 60, VBP + GY0 + 158 + k, 1, ~k[0], k[1], 1);
      step(HBP + GX0 - 1 + k, VBP + GY0 - 1 + k, 1, 1, ~k[1], 1);
    end
    pad(4);

    // randomized raster positions, cursor and blink enable changes
    for (int n = 0; n < 1600; n++) begin
      if (n % 100 == 0) begin
        pad(3);
        posx = 4'($urandom_range(0, 15));
        posy = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 2) == 0) begin posx = 4'($urandom_range(0, 3)); posy = 4'($urandom_range(0, 3)); end
        blink_en = 1'($urandom_range(0, 1));
      end
      do begin
        if ($urandom_range(0, 1) == 1) begin
          h = HBP + GX0 - 3 + $urandom_range(0, COLS * TILE + 5);
          v = VBP + GY0 - 3 + $urandom_range(0, ROWS * TILE + 5);
          if ($urandom_range(0, 3) == 0) begin
            h = HBP + GX0 + 16 * $urandom_range(0, 3) + $urandom_range(0, 15);
            v = VBP + GY0 + 16 * $urandom_range(0, 3) + $urandom_range(0, 15);
          end
        end else begin
          h = $urandom_range(0, 799);
          v = $urandom_range(0, 520);
        end
      end while (in_face(h, v) || (h == 0 && v == 0));
      step(h, v, $urandom_range(0, 4) != 0, $urandom_range(0, 1), $urandom_range(0, 1), 1);
    end
    pad(4);

    // full face scan with one margin pixel on every side
    for (int fy = -1; fy <= FH; fy++) begin
      for (int fx = -1; fx <= FW; fx++) begin
        step(HBP + FX0 + fx, VBP + FY0 + fy, 1, fx != -1, fy != -1, 1);
        if (fx == 5 && fy == 3) begin
          @(posedge clk); #1;
          chk("face_addr_83", af0, 10'd83);
        end
      end
    end
    pad(4);

    // blink: restart from reset, cursor on tile (3,4)
    step(5, 5, 0, 1, 1, 0);
    step(6, 5, 0, 1, 1, 0);
    pad(2);
    posx = 4'd3; posy = 4'd4; blink_en = 1; ovr_en = 1; ovr_val = 8'hA5;
    pad(3);
    probe("blink_start", 434, 297, 8'hA5, 8'hA5);
    for (int f = 0; f < 6; f++) begin
      step(0, 0, 0, 1, 1, 1);
      pad(3);
      tk = f + 1;
      if ((tk / BFR) % 2 == 1) probe("blink_on", 434, 297, 8'hC5, 8'h5A);
      else                     probe("blink_off", 434, 297, 8'hA5, 8'hA5);
      step(HBP + GX0 + 48 + f, VBP + GY0 + 64 + f, 1, 0, 1, 1);
      pad(3);
    end
    // mid-frame reset restarts the blink phase
    step(434, 297, 1, 1, 1, 0);
    step(435, 297, 1, 1, 1, 0);
    pad(3);
    probe("blink_rst", 434, 297, 8'hA5, 8'hA5);
    for (int f = 0; f < 4; f++) begin
      step(0, 0, 0, 1, 1, 1);
      pad(3);
      tk = f + 1;
      if ((tk / BFR) % 2 == 1) probe("blink2_on", 434, 297, 8'hC5, 8'h5A);
      else                     probe("blink2_off", 434, 297, 8'hA5, 8'hA5);
    end
    ovr_en = 0;
    pad(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_grid_sprite.md
Name: vga_grid_sprite

Overview:
- Parametrised, pipelined successor of the board/face sprite renderer for the MineSweeper VGA path.
- Maps the raster position (hc/vc) onto a ROWS x COLS tile board and a FACE_W x FACE_H face sprite, issues registered ROM addresses, and returns registered 8-bit RGB (3/3/2).
- Adds a blinking cursor highlight with a selectable mode, and delays hsync/vsync so they stay aligned with the pipelined colour.

Parameters:
- HBP, 144, horizontal back-porch offset in hc.
- VBP, 31, vertical back-porch offset in vc.
- GX0, 240, board left edge (pixels after HBP).
- GY0, 200, board top edge (pixels after VBP).
- COLS, 10, board columns (1..16).
- ROWS, 10, board rows (1..16).
- TL2, 4, log2 of tile edge; tile = 2^TL2 pixels square.
- FX0, 307, face left edge.
- FY0, 174, face top edge.
- FACE_W, 26, face width in pixels.
- FACE_H, 26, face height in pixels.
- FAW, 10, face ROM address width.
- BLINK_FR, 30, frames per blink half-period (>=1).
- HL_MODE, 0, cursor highlight: 0 = red saturating +1, 1 = bitwise invert RGB.

Ports:
- clk  in  1  pixel clock
- clr_n  in  1  asynchronous active-low reset
- vidon  in  1  visible-area flag, aligned with hc/vc
- hs_in  in  1  hsync, aligned with hc/vc
- vs_in  in  1  vsync, aligned with hc/vc
- hc  in  10  horizontal counter
- vc  in  10  vertical counter
- posx  in  4  cursor column
- posy  in  4  cursor row
- blink_en  in  1  1 = cursor blinks; 0 = highlight always shown
- tile_col  out  4  board column of the current pixel (board-state lookup)
- tile_row  out  4  board row of the current pixel
- rom_addr_tile  out  2*TL2  {ypix, xpix} within the tile
- rom_addr_face  out  FAW  fy*FACE_W + fx
- tile_pix  in  8  tile ROM data, valid one clock after the addresses
- face_pix  in  8  face ROM data, valid one clock after the addresses
- red  out  3  colour
- green  out  3  colour
- blue  out  2  colour
- hs_out  out  1  hsync delayed by 3 clocks
- vs_out  out  1  vsync delayed by 3 clocks

Behaviour:
- Reset (clr_n = 0, asynchronous): all address outputs, tile_col, tile_row, red, green and blue are 0. hs_out and vs_out are 1 (inactive). The pipeline valid bits, frame counter and blink phase are 0. Reset mid-frame blanks the output immediately; normal output resumes three clocks after release.
- Stage 1 (register): x = hc - HBP, y = vc - VBP (10-bit, wrapping).
  - board_on = GX0 <= x < GX0 + COLS*2^TL2 and GY0 <= y < GY0 + ROWS*2^TL2.
  - face_on = FX0 <= x < FX0 + FACE_W and FY0 <= y < FY0 + FACE_H. board_on has priority if the two regions overlap.
  - tile_col = (x - GX0) >> TL2; tile_row = (y - GY0) >> TL2; rom_addr_tile = low TL2 bits of y-offset concatenated with low TL2 bits of x-offset.
  - rom_addr_face: incremental, not a multiplier.
    - A line-base register loads 0 on the first face line and adds FACE_W on each later face line, updated when x == FX0.
    - The column counter resets to 0 at x == FX0 and increments while face_on.
    - rom_addr_face = base + column, truncated to FAW bits.
  - Outside their region, the address outputs hold their last value.
- Stage 2: register board_on, face_on, vidon and cursor_hit (tile_col == posx and tile_row == posy). This aligns them with the ROM data.
- Stage 3 (register RGB):
  - if vidon and board_on: use tile_pix, apply the highlight when cursor_hit and show_hl are both 1;
  - else if vidon and face_on: use face_pix;
  - else: 0.
- Highlight modes:
  - Mode 0: red = min(red + 1, 7); green and blue unchanged.
  - Mode 1: {r, g, b} = ~pix.
- hs/vs pass through a 3-deep shift register, so RGB, hs_out and vs_out share the same 3-clock latency from hc/vc.
- Blink:
  - A frame tick fires on the clock where hc == 0 and vc == 0.
  - The frame counter counts 0..BLINK_FR-1. On wrap it returns to 0 and toggles the phase.
  - show_hl = ~blink_en | phase.
  - posx/posy outside the board never match, so no highlight is drawn.

Decomposition:
- Package vga_pkg holds: the default timing constants (HBP, VBP, HMAX = 800, VMAX = 521), an rgb332 field split helper, and the highlight-mode encodings.
- Sub-module vga_blink_ctr (frame-tick detection, frame counter, phase).
- The render pipeline stays in the top module.

Test Plan:
- Reset: hold clr_n = 0 while sweeping pixels -> RGB = 0, hs_out = vs_out = 1. Release -> first valid RGB appears 3 clocks after the first hc/vc sample.
- Board mapping (default parameters): hc = 144+240+35, vc = 31+200+18 -> tile_col = 2, tile_row = 1, rom_addr_tile = 0x23. tile_pix = 0xA5 -> RGB = 5/1/1 three clocks later.
- Cursor, mode 0: posx = 2, posy = 1, blink_en = 0, tile_pix = 0xE4 -> red saturates at 7, green 1, blue 0. HL_MODE = 1 with tile_pix = 0xA5 -> output 0x5A.
- Face addressing: pixel (FX0+5, FY0+3) -> rom_addr_face = 83. A full face scan produces addresses 0..675, each exactly once, in order.
- Blink, BLINK_FR = 2, blink_en = 1: cursor visible on 2 frames, hidden on the next 2, repeating. Reset mid-frame restarts with phase 0 (hidden).
- Boundaries: x = GX0 + 159 is on the board, x = GX0 + 160 is off. vidon = 0 inside the board gives black. hs/vs edges appear on the outputs exactly 3 clocks later.
